// File: rtl/seg_scan_decoder.sv
// Seven-segment bus monitor: synchronizes a multiplexed display bus, filters scan glitches
// and reconstructs the displayed hex value one complete frame at a time.
module seg_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter bit          ACTIVE_LOW    = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                seg_in,
    input  logic                      dp_in,
    input  logic [NUM_DIGITS-1:0]     dig_en,
    output logic [4*NUM_DIGITS-1:0]   value_out,
    output logic [NUM_DIGITS-1:0]     dp_out,
    output logic                      frame_valid,
    output logic                      frame_err
);

    localparam int unsigned VecW   = NUM_DIGITS + 8;
    localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0]  CntMax = 8'(STABLE_CYCLES - 1);

    logic [VecW-1:0]         sync1_q, sync1_d;
    logic [VecW-1:0]         s_q, s_d;
    logic [VecW-1:0]         s_prev_q, s_prev_d;
    logic [7:0]              stab_cnt_q, stab_cnt_d;
    logic                    captured_q, captured_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] shadow_nib_q, shadow_nib_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d;
    logic                    publish_q, publish_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   dp_out_q, dp_out_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    frame_err_q, frame_err_d;

    logic [NUM_DIGITS-1:0]   en;
    logic                    dp;
    logic [6:0]              seg;
    logic                    en_onehot;
    logic [IdxW-1:0]         idx;
    logic [3:0]              dec_nib;
    logic                    dec_bad;
    logic                    stable;
    logic                    capture;

    assign en        = s_q[VecW-1:8];
    assign dp        = s_q[7];
    assign seg       = s_q[6:0];
    assign en_onehot = $onehot(en);

    // Polarity is normalised before the synchronizer so everything downstream is active-high.
    always_comb begin
        sync1_d = {dig_en, dp_in, seg_in};
        if (ACTIVE_LOW) begin
            sync1_d = ~sync1_d;
        end
        s_d      = sync1_q;
        s_prev_d = s_q;
    end

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (en[i]) begin
                idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        dec_nib = 4'h0;
        dec_bad = 1'b0;
        case (seg)
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h07: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h6F: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h39: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
            default: begin
                dec_nib = 4'h0;
                dec_bad = 1'b1;
            end
        endcase
    end

    // Capture also requires the current sample to match, so a change arriving just as the
    // counter saturates is never mistaken for the settled value.
    assign stable  = (s_q == s_prev_q) && en_onehot;
    assign capture = stable && (stab_cnt_q == CntMax) && !captured_q;

    always_comb begin
        stab_cnt_d = 8'd0;
        if (stable) begin
            stab_cnt_d = (stab_cnt_q == CntMax) ? stab_cnt_q : stab_cnt_q + 8'd1;
        end
        captured_d = stable && (captured_q || capture);
    end

    // A publish empties the mask; a capture on that same edge starts the next frame.
    always_comb begin
        mask_d       = publish_q ? '0 : mask_q;
        shadow_err_d = publish_q ? '0 : shadow_err_q;
        shadow_nib_d = shadow_nib_q;
        shadow_dp_d  = shadow_dp_q;
        if (capture) begin
            mask_d[idx]               = 1'b1;
            shadow_nib_d[4*idx +: 4]  = dec_nib;
            shadow_dp_d[idx]          = dp;
            shadow_err_d[idx]         = dec_bad;
        end
        publish_d = capture && (&mask_d);
    end

    always_comb begin
        value_d       = publish_q ? shadow_nib_q : value_q;
        dp_out_d      = publish_q ? shadow_dp_q : dp_out_q;
        frame_err_d   = publish_q ? (|shadow_err_q) : frame_err_q;
        frame_valid_d = publish_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= '0;
            s_q           <= '0;
            s_prev_q      <= '0;
            stab_cnt_q    <= 8'd0;
            captured_q    <= 1'b0;
            mask_q        <= '0;
            shadow_nib_q  <= '0;
            shadow_dp_q   <= '0;
            shadow_err_q  <= '0;
            publish_q     <= 1'b0;
            value_q       <= '0;
            dp_out_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            s_q           <= s_d;
            s_prev_q      <= s_prev_d;
            stab_cnt_q    <= stab_cnt_d;
            captured_q    <= captured_d;
            mask_q        <= mask_d;
            shadow_nib_q  <= shadow_nib_d;
            shadow_dp_q   <= shadow_dp_d;
            shadow_err_q  <= shadow_err_d;
            publish_q     <= publish_d;
            value_q       <= value_d;
            dp_out_q      <= dp_out_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign value_out   = value_q;
    assign dp_out      = dp_out_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule
